coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Shared-bus responder for two MSI data-cache controllers (CPU0, CPU1).
- Latches each cache's one-cycle read_miss / write_miss / invalidate pulses.
- Arbitrates round-robin, snoops the peer cache, and selects the fill source (unified memory or peer cache).
- Broadcasts invalidates to the peer and grants the bus until the unified-memory transfer completes.

Parameters:
MEM_TIMEOUT, 64, max cycles grant is held waiting for mem_rdy before abort
FWD_GRANT_CYC, 2, grant hold cycles when the peer cache supplies data

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
read_miss  in  2  per-CPU read-miss pulse (bit i = CPUi)
write_miss  in  2  per-CPU write-miss pulse
invalidate  in  2  per-CPU write-hit-on-SHARED invalidate pulse
BICO_0  in  13  CPU0 bus address, valid with CPU0 pulses
BICO_1  in  13  CPU1 bus address, valid with CPU1 pulses
cpu_search_found  in  2  per-CPU snoop hit response
snoop_data_0  in  64  CPU0 line returned on snoop
snoop_data_1  in  64  CPU1 line returned on snoop
mem_rdy  in  1  unified memory ready
grant  out  2  per-CPU bus grant
cpu_search  out  2  per-CPU snoop request
BOCI_0  out  13  address presented to CPU0 for snoop/invalidate
BOCI_1  out  13  address presented to CPU1 for snoop/invalidate
cpu_datasel_0  out  2  CPU0 fill source: 00 DMEM, 01 OTHER_PROC
cpu_datasel_1  out  2  CPU1 fill source
other_proc_data_0  out  64  forwarded line to CPU0
other_proc_data_1  out  64  forwarded line to CPU1
invalidate_from_other_cpu  out  2  per-CPU invalidate command
busy  out  1  state != IDLE
timeout_err  out  1  sticky, set on memory timeout

Behaviour:
- Reset (async): state IDLE, rr pointer = 0, all pending bits = 0, all outputs 0, datasel = 00, timeout_err = 0. Reset mid-transaction aborts it; pending requests are lost.
- Pending capture, per CPU i, every cycle:
  - A pulse sets pend_rd[i] / pend_wr[i] / pend_inv[i] and loads addr_q[i] = BICO_i.
  - read_miss and write_miss together from one CPU: write wins.
  - Set beats clear in the same cycle. Repeated pulses are idempotent.
- Peer of requester r is p = ~r. BOCI_p = addr_q[r] in INV, SNOOP, RESP and XFER; otherwise 0.
- States:
  - IDLE:
    - Invalidates take priority over misses.
    - If any pend_inv, pick r by rr pointer (pointer CPU first if both pending) -> INV.
    - Else if any pend_rd or pend_wr, pick r the same way, latch type -> SNOOP.
  - INV (1 cycle): invalidate_from_other_cpu[p] = 1; clear pend_inv[r]; -> IDLE. The rr pointer is unchanged.
  - SNOOP (1 cycle): cpu_search[p] = 1 -> RESP.
  - RESP (1 cycle): cpu_search[p] still 1.
    - Register found_q = cpu_search_found[p] and fwd_q = snoop_data_p.
    - src = OTHER_PROC if read & found_q, else DMEM.
    - -> XFER.
  - XFER:
    - Drive grant[r] = 1, cpu_datasel_r = src, other_proc_data_r = fwd_q. All are stable for the whole state.
    - Write miss with found_q: pulse invalidate_from_other_cpu[p] in the first XFER cycle only.
    - src OTHER_PROC: hold FWD_GRANT_CYC cycles -> DONE.
    - src DMEM: hold until the cycle mem_rdy = 1 (grant still high that cycle) -> DONE.
    - Timeout counter resets on XFER entry. When it reaches MEM_TIMEOUT without mem_rdy: set timeout_err, -> DONE.
  - DONE (1 cycle): clear pend_rd[r] and pend_wr[r] unless re-set this cycle; rr pointer = p; -> IDLE.
- Invalidate from r while r has a miss in flight: stays pending and is served after DONE.
- Same-line invalidates from both CPUs: served in rr order; both peers receive invalidate_from_other_cpu.
- grant is one-hot or zero at all times. cpu_datasel_x = 00 whenever grant[x] = 0.
- Latencies:
  - Pulse to grant (idle bus, no pending invalidate): 4 cycles (capture, IDLE decision, SNOOP, RESP).
  - Invalidate pulse to invalidate_from_other_cpu: 2 cycles.

Test Plan:
- CPU0 read_miss, BICO_0=0x0A4, CPU1 found=0 -> cpu_search[1] 2 cycles with BOCI_1=0x0A4; grant[0] with datasel_0=00 held until mem_rdy; then IDLE, rr=1.
- CPU1 read_miss, BICO_1=0x155, CPU0 found=1, snoop_data_0=64'hDEAD_BEEF_0123_4567 -> grant[1], datasel_1=01, other_proc_data_1 equals that line for 2 cycles; no mem wait.
- CPU0 invalidate, BICO_0=0x010 -> invalidate_from_other_cpu[1]=1 for exactly 1 cycle with BOCI_1=0x010; grant stays 0.
- Same-cycle read_miss from both, rr=0 -> CPU0 served first, CPU1 granted immediately after CPU0's DONE.
- Write miss CPU1, CPU0 found=1 -> datasel_1=00, invalidate_from_other_cpu[0] pulsed once in the first XFER cycle.
- mem_rdy held low -> after 64 XFER cycles timeout_err=1 (sticky), grant drops. Async reset mid-XFER -> all outputs 0 immediately.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Shared-bus responder for two MSI data caches: captures miss/invalidate
// pulses, arbitrates round-robin, snoops the peer and grants the bus.
module coherence_bus_ctrl #(
    parameter int MEM_TIMEOUT   = 64,
    parameter int FWD_GRANT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  read_miss,
    input  logic [1:0]  write_miss,
    input  logic [1:0]  invalidate,
    input  logic [12:0] BICO_0,
    input  logic [12:0] BICO_1,
    input  logic [1:0]  cpu_search_found,
    input  logic [63:0] snoop_data_0,
    input  logic [63:0] snoop_data_1,
    input  logic        mem_rdy,
    output logic [1:0]  grant,
    output logic [1:0]  cpu_search,
    output logic [12:0] BOCI_0,
    output logic [12:0] BOCI_1,
    output logic [1:0]  cpu_datasel_0,
    output logic [1:0]  cpu_datasel_1,
    output logic [63:0] other_proc_data_0,
    output logic [63:0] other_proc_data_1,
    output logic [1:0]  invalidate_from_other_cpu,
    output logic        busy,
    output logic        timeout_err
);
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INV, S_SNOOP, S_RESP, S_XFER, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d, r_q, r_d, wr_q, wr_d;
    logic          found_q, found_d, src_q, src_d;
    logic [1:0]    pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [1:0]    pend_inv_q, pend_inv_d;
    logic [12:0]   addr0_q, addr0_d, addr1_q, addr1_d;
    logic [63:0]   fwd_q, fwd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic [1:0]    grant_q, grant_d, search_q, search_d;
    logic [12:0]   boci0_q, boci0_d, boci1_q, boci1_d;
    logic [1:0]    ds0_q, ds0_d, ds1_q, ds1_d, inv_q, inv_d;
    logic [63:0]   opd0_q, opd0_d, opd1_q, opd1_d;
    logic          busy_q, busy_d;
    logic          xfer_d, active_d;
    logic [1:0]    rmask_d, pmask_d;
    logic [12:0]   addr_r_d;

    // Pointer CPU wins only when both are asking.
    function automatic logic pick(input logic [1:0] m, input logic ptr);
        return (&m) ? ptr : m[1];
    endfunction

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        r_d           = r_q;
        wr_d          = wr_q;
        found_d       = found_q;
        src_d         = src_q;
        pend_rd_d     = pend_rd_q;
        pend_wr_d     = pend_wr_q;
        pend_inv_d    = pend_inv_q;
        fwd_d         = fwd_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (|pend_inv_q) begin
                    r_d     = pick(pend_inv_q, rr_q);
                    state_d = S_INV;
                end else if (|(pend_rd_q | pend_wr_q)) begin
                    r_d     = pick(pend_rd_q | pend_wr_q, rr_q);
                    wr_d    = pend_wr_q[r_d];
                    state_d = S_SNOOP;
                end
            end
            S_INV: begin
                pend_inv_d[r_q] = 1'b0;
                state_d         = S_IDLE;
            end
            S_SNOOP: state_d = S_RESP;
            S_RESP: begin
                found_d = cpu_search_found[~r_q];
                fwd_d   = r_q ? snoop_data_0 : snoop_data_1;
                src_d   = ~wr_q & found_d;
                cnt_d   = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                if (src_q) begin
                    if (cnt_q == CW'(FWD_GRANT_CYC - 1)) state_d = S_DONE;
                    else cnt_d = cnt_q + 1'b1;
                end else if (mem_rdy) begin
                    state_d = S_DONE;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                pend_rd_d[r_q] = 1'b0;
                pend_wr_d[r_q] = 1'b0;
                rr_d           = ~r_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // New pulses override any clear above; write beats read.
        pend_wr_d  = pend_wr_d | write_miss;
        pend_rd_d  = (pend_rd_d | read_miss) & ~write_miss;
        pend_inv_d = pend_inv_d | invalidate;
        addr0_d    = (read_miss[0] | write_miss[0] | invalidate[0]) ? BICO_0 : addr0_q;
        addr1_d    = (read_miss[1] | write_miss[1] | invalidate[1]) ? BICO_1 : addr1_q;

        xfer_d   = state_d == S_XFER;
        active_d = state_d inside {S_INV, S_SNOOP, S_RESP, S_XFER};
        rmask_d  = r_d ? 2'b10 : 2'b01;
        pmask_d  = ~rmask_d;
        addr_r_d = r_d ? addr1_d : addr0_d;
        grant_d  = xfer_d ? rmask_d : 2'b00;
        search_d = (state_d == S_SNOOP || state_d == S_RESP) ? pmask_d : 2'b00;
        boci0_d  = (active_d && r_d) ? addr_r_d : 13'd0;
        boci1_d  = (active_d && !r_d) ? addr_r_d : 13'd0;
        ds0_d    = (xfer_d && !r_d) ? {1'b0, src_d} : 2'b00;
        ds1_d    = (xfer_d && r_d) ? {1'b0, src_d} : 2'b00;
        opd0_d   = (xfer_d && !r_d) ? fwd_d : 64'd0;
        opd1_d   = (xfer_d && r_d) ? fwd_d : 64'd0;
        // Peer invalidate: INV state, or first XFER cycle of a write that hit.
        inv_d    = (state_d == S_INV || (state_q == S_RESP && wr_q && found_d))
                   ? pmask_d : 2'b00;
        busy_d   = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_q          <= 1'b0;
            r_q           <= 1'b0;
            wr_q          <= 1'b0;
            found_q       <= 1'b0;
            src_q         <= 1'b0;
            pend_rd_q     <= 2'b00;
            pend_wr_q     <= 2'b00;
            pend_inv_q    <= 2'b00;
            addr0_q       <= 13'd0;
            addr1_q       <= 13'd0;
            fwd_q         <= 64'd0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            grant_q       <= 2'b00;
            search_q      <= 2'b00;
            boci0_q       <= 13'd0;
            boci1_q       <= 13'd0;
            ds0_q         <= 2'b00;
            ds1_q         <= 2'b00;
            opd0_q        <= 64'd0;
            opd1_q        <= 64'd0;
            inv_q         <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            r_q           <= r_d;
            wr_q          <= wr_d;
            found_q       <= found_d;
            src_q         <= src_d;
            pend_rd_q     <= pend_rd_d;
            pend_wr_q     <= pend_wr_d;
            pend_inv_q    <= pend_inv_d;
            addr0_q       <= addr0_d;
            addr1_q       <= addr1_d;
            fwd_q         <= fwd_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            grant_q       <= grant_d;
            search_q      <= search_d;
            boci0_q       <= boci0_d;
            boci1_q       <= boci1_d;
            ds0_q         <= ds0_d;
            ds1_q         <= ds1_d;
            opd0_q        <= opd0_d;
            opd1_q        <= opd1_d;
            inv_q         <= inv_d;
            busy_q        <= busy_d;
        end
    end

    assign grant                     = grant_q;
    assign cpu_search                = search_q;
    assign BOCI_0                    = boci0_q;
    assign BOCI_1                    = boci1_q;
    assign cpu_datasel_0             = ds0_q;
    assign cpu_datasel_1             = ds1_q;
    assign other_proc_data_0         = opd0_q;
    assign other_proc_data_1         = opd1_q;
    assign invalidate_from_other_cpu = inv_q;
    assign busy                      = busy_q;
    assign timeout_err               = timeout_err_q;
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: per-cycle expected output timelines built
// from transaction-level rules, compared against the sampled outputs.
module tb_coherence_bus_ctrl;
    localparam int MT   = 64;
    localparam int FG   = 2;
    localparam int MAXC = 128;

    typedef logic [165:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  read_miss, write_miss, invalidate, cpu_search_found;
    logic [12:0] BICO_0, BICO_1;
    logic [63:0] snoop_data_0, snoop_data_1;
    logic        mem_rdy;
    logic [1:0]  grant, cpu_search, cpu_datasel_0, cpu_datasel_1;
    logic [12:0] BOCI_0, BOCI_1;
    logic [63:0] other_proc_data_0, other_proc_data_1;
    logic [1:0]  invalidate_from_other_cpu;
    logic        busy, timeout_err;

    coherence_bus_ctrl #(.MEM_TIMEOUT(MT), .FWD_GRANT_CYC(FG)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss(read_miss), .write_miss(write_miss),
        .invalidate(invalidate),
        .BICO_0(BICO_0), .BICO_1(BICO_1),
        .cpu_search_found(cpu_search_found),
        .snoop_data_0(snoop_data_0), .snoop_data_1(snoop_data_1),
        .mem_rdy(mem_rdy),
        .grant(grant), .cpu_search(cpu_search),
        .BOCI_0(BOCI_0), .BOCI_1(BOCI_1),
        .cpu_datasel_0(cpu_datasel_0), .cpu_datasel_1(cpu_datasel_1),
        .other_proc_data_0(other_proc_data_0),
        .other_proc_data_1(other_proc_data_1),
        .invalidate_from_other_cpu(invalidate_from_other_cpu),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    vec_t        expv [MAXC];
    vec_t        obsv [MAXC];
    logic [1:0]  s_rd [MAXC];
    logic [1:0]  s_wr [MAXC];
    logic [1:0]  s_inv [MAXC];
    logic [12:0] s_a0 [MAXC];
    logic [12:0] s_a1 [MAXC];
    logic        s_rdy [MAXC];
    logic [1:0]  fnd;
    logic [63:0] sd0, sd1;
    logic        tmo_m, rr_m;
    int          total = 0;
    int          bad = 0;

    function automatic vec_t pack(input logic [1:0] g, cs,
                                  input logic [12:0] b0, b1,
                                  input logic [1:0] d0, d1, iv,
                                  input logic bz, te,
                                  input logic [63:0] o0, o1);
        return {g, cs, b0, b1, d0, d1, iv, bz, te, o0, o1};
    endfunction

    function automatic vec_t cur();
        return pack(grant, cpu_search, BOCI_0, BOCI_1, cpu_datasel_0,
                    cpu_datasel_1, invalidate_from_other_cpu, busy,
                    timeout_err, other_proc_data_0, other_proc_data_1);
    endfunction

    task automatic clear_sched();
        for (int k = 0; k < MAXC; k++) begin
            s_rd[k]  = 2'b00;
            s_wr[k]  = 2'b00;
            s_inv[k] = 2'b00;
            s_a0[k]  = 13'($urandom);
            s_a1[k]  = 13'($urandom);
            s_rdy[k] = 1'b0;
            expv[k]  = '0;
            expv[k][128] = tmo_m;
        end
    endtask

    // kind: 0 invalidate, 1 read miss, 2 write miss
    task automatic pulse(input int k, input int kind, input logic r,
                         input logic [12:0] a);
        case (kind)
            0: s_inv[k][r] = 1'b1;
            1: s_rd[k][r] = 1'b1;
            default: s_wr[k][r] = 1'b1;
        endcase
        if (r) s_a1[k] = a;
        else s_a0[k] = a;
    endtask

    // Adds one served request whose IDLE decision happens at cycle sh+1.
    task automatic add_txn(input int sh, input int kind, input logic r,
                           input logic [12:0] a, input int dly,
                           output int len);
        logic p, fw, inx, bb;
        logic [1:0] pm, rm, ds, iv;
        logic [12:0] b0, b1;
        logic [63:0] dat;
        p  = ~r;
        pm = p ? 2'b10 : 2'b01;
        rm = ~pm;
        b0 = p ? 13'd0 : a;
        b1 = p ? a : 13'd0;
        if (kind == 0) begin
            len = 0;
            expv[sh+2] |= pack(2'b00, 2'b00, b0, b1, 2'b00, 2'b00, pm,
                               1'b1, 1'b0, 64'd0, 64'd0);
        end else begin
            fw  = (kind == 1) && fnd[p];
            dat = p ? sd1 : sd0;
            len = fw ? FG : ((dly < MT) ? dly + 1 : MT);
            if (!fw && dly < MT) s_rdy[sh+4+dly] = 1'b1;
            for (int k = sh + 2; k <= sh + 4 + len; k++) begin
                inx = (k >= sh + 4) && (k < sh + 4 + len);
                bb  = k < sh + 4 + len;
                ds  = (inx && fw) ? 2'b01 : 2'b00;
                iv  = (k == sh + 4 && kind == 2 && fnd[p]) ? pm : 2'b00;
                expv[k] |= pack(inx ? rm : 2'b00,
                                (k < sh + 4) ? pm : 2'b00,
                                bb ? b0 : 13'd0, bb ? b1 : 13'd0,
                                r ? 2'b00 : ds, r ? ds : 2'b00, iv,
                                1'b1, 1'b0,
                                (inx && !r) ? dat : 64'd0,
                                (inx && r) ? dat : 64'd0);
            end
            if (!fw && dly >= MT) begin
                tmo_m = 1'b1;
                for (int k = sh + 4 + len; k < MAXC; k++) expv[k][128] = 1'b1;
            end
            rr_m = p;
        end
    endtask

    task automatic run_window(input int n);
        for (int k = 0; k < n; k++) begin
            read_miss  = s_rd[k];
            write_miss = s_wr[k];
            invalidate = s_inv[k];
            BICO_0     = s_a0[k];
            BICO_1     = s_a1[k];
            mem_rdy    = s_rdy[k];
            cpu_search_found = fnd;
            snoop_data_0 = sd0;
            snoop_data_1 = sd1;
            @(posedge clk);
            @(negedge clk);
            obsv[k+1] = cur();
        end
        read_miss  = 2'b00;
        write_miss = 2'b00;
        invalidate = 2'b00;
        mem_rdy    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        read_miss = 2'b00; write_miss = 2'b00; invalidate = 2'b00;
        BICO_0 = 13'd0; BICO_1 = 13'd0; mem_rdy = 1'b0;
        cpu_search_found = 2'b00; snoop_data_0 = 64'd0; snoop_data_1 = 64'd0;
        tmo_m = 1'b0; rr_m = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cur() !== '0) begin
            bad++;
            $display("FAIL reset got=%h exp=0", cur());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_dmem();
        int len, n;
        fnd = 2'b00; sd0 = 64'h1111; sd1 = 64'h0BAD_F00D_0000_2222;
        clear_sched();
        pulse(0, 1, 1'b0, 13'h0A4);
        add_txn(0, 1, 1'b0, 13'h0A4, 3, len);
        n = len + 7;
        run_window(n);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL read_dmem cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_read_fwd();
        int len, n;
        fnd = 2'b01; sd0 = 64'hDEAD_BEEF_0123_4567; sd1 = 64'h5;
        clear_sched();
        pulse(0, 1, 1'b1, 13'h155);
        add_txn(0, 1, 1'b1, 13'h155, 0, len);
        n = len + 7;
        run_window(n);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL read_fwd cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_invalidate();
        int len;
        fnd = 2'b11; sd0 = 64'd7; sd1 = 64'd9;
        clear_sched();
        pulse(0, 0, 1'b0, 13'h010);
        add_txn(0, 0, 1'b0, 13'h010, 0, len);
        run_window(5);
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL invalidate cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_write_found();
        int len, n;
        fnd = 2'b01; sd0 = 64'hCAFE_0000_1234_5678; sd1 = 64'd3;
        clear_sched();
        pulse(0, 2, 1'b1, 13'h1F0);
        add_txn(0, 2, 1'b1, 13'h1F0, 2, len);
        n = len + 7;
        run_window(n);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL write_found cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_random_single();
        int len, n, kind, dly;
        logic r;
        logic [12:0] a;
        for (int i = 0; i < 8; i++) begin
            r = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            dly = $urandom_range(0, 5);
            a = 13'($urandom);
            fnd = 2'($urandom);
            sd0 = {$urandom, $urandom};
            sd1 = {$urandom, $urandom};
            clear_sched();
            pulse(0, kind, r, a);
            add_txn(0, kind, r, a, dly, len);
            n = len + 7;
            run_window(n);
            for (int k = 1; k <= n; k++) begin
                total++;
                if (obsv[k] !== expv[k]) begin
                    bad++;
                    $display("FAIL random_single it=%0d cyc=%0d got=%h exp=%h", i, k, obsv[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int l1, l2, n, d1, d2, kind;
        logic f;
        logic [12:0] a0, a1;
        for (int i = 0; i < 3; i++) begin
            kind = (i == 0) ? 1 : $urandom_range(1, 2);
            d1 = $urandom_range(0, 4);
            d2 = $urandom_range(0, 4);
            a0 = 13'($urandom);
            a1 = 13'($urandom);
            fnd = 2'($urandom);
            sd0 = {$urandom, $urandom};
            sd1 = {$urandom, $urandom};
            clear_sched();
            pulse(0, kind, 1'b0, a0);
            pulse(0, kind, 1'b1, a1);
            f = rr_m;
            add_txn(0, kind, f, f ? a1 : a0, d1, l1);
            add_txn(4 + l1, kind, ~f, f ? a0 : a1, d2, l2);
            n = l1 + l2 + 11;
            run_window(n);
            for (int k = 1; k <= n; k++) begin
                total++;
                if (obsv[k] !== expv[k]) begin
                    bad++;
                    $display("FAIL back_to_back it=%0d cyc=%0d got=%h exp=%h", i, k, obsv[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_dual_inv();
        int len;
        logic f;
        logic [12:0] a;
        a = 13'h0C3;
        fnd = 2'b00; sd0 = 64'd0; sd1 = 64'd0;
        clear_sched();
        pulse(0, 0, 1'b0, a);
        pulse(0, 0, 1'b1, a);
        f = rr_m;
        add_txn(0, 0, f, a, 0, len);
        add_txn(2, 0, ~f, a, 0, len);
        run_window(7);
        for (int k = 1; k <= 7; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL dual_inv cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_inv_during_miss();
        int len, l2, n;
        logic r;
        logic [12:0] a;
        r = 1'($urandom_range(0, 1));
        a = 13'($urandom);
        fnd = 2'b00; sd0 = {$urandom, $urandom}; sd1 = {$urandom, $urandom};
        clear_sched();
        pulse(0, 1, r, a);
        pulse(3, 0, r, a);
        add_txn(0, 1, r, a, 2, len);
        add_txn(4 + len, 0, r, a, 0, l2);
        n = len + 10;
        run_window(n);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL inv_during_miss cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int len, n;
        fnd = 2'b00; sd0 = 64'h77; sd1 = 64'h88;
        clear_sched();
        pulse(0, 1, 1'b1, 13'h0EE);
        add_txn(0, 1, 1'b1, 13'h0EE, MT, len);
        n = len + 8;
        run_window(n);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int len;
        fnd = 2'b00; sd0 = 64'h1234; sd1 = 64'h5678;
        clear_sched();
        pulse(0, 1, 1'b0, 13'h0AB);
        add_txn(0, 1, 1'b0, 13'h0AB, 40, len);
        run_window(6);
        for (int k = 1; k <= 6; k++) begin
            total++;
            if (obsv[k] !== expv[k]) begin
                bad++;
                $display("FAIL async_reset_pre cyc=%0d got=%h exp=%h", k, obsv[k], expv[k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (cur() !== '0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=0", cur());
        end
        tmo_m = 1'b0;
        rr_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_read_dmem();
        test_read_fwd();
        test_invalidate();
        test_write_found();
        test_random_single();
        test_back_to_back();
        test_dual_inv();
        test_inv_during_miss();
        test_timeout();
        test_random_single();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
